// File: rtl/line_buf_pkg.sv
// Shared defaults and types for the one-line-delay controller in front of the line RAM.
package line_buf_pkg;

    localparam int LB_DATA_WIDTH = 8;
    localparam int LB_ADDR_WIDTH = 11;
    localparam int LB_MAX_PIXELS = 2048;

    typedef logic [LB_DATA_WIDTH-1:0] pix_t;
    // One extra bit so a column counter can hold MAX_PIXELS itself.
    typedef logic [LB_ADDR_WIDTH:0]   col_t;

endpackage

// File: rtl/line_buf_ctrl.sv
// Line-delay controller: writes each line into the line RAM and pairs every pixel
// with the stored pixel at the same column of the previous line, two cycles later.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int DATA_WIDTH = LB_DATA_WIDTH,
    parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
    parameter int MAX_PIXELS = LB_MAX_PIXELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    input  logic                  in_eol,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_cur,
    output logic [DATA_WIDTH-1:0] out_prev,
    output logic                  out_prev_vld,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic [ADDR_WIDTH:0]   line_len,
    output logic                  ovf_err
);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;

    localparam cnt_t MAX_COL = cnt_t'(MAX_PIXELS);

    // Line bookkeeping
    cnt_t  col_q, col_d;
    logic  first_line_q, first_line_d;
    cnt_t  prev_len_q, prev_len_d;
    cnt_t  line_len_q, line_len_d;
    logic  ovf_err_q, ovf_err_d;

    // Stage 1: pixel waiting for its RAM read data; also the write port
    logic  s1_valid_q, s1_valid_d;
    data_t s1_data_q, s1_data_d;
    cnt_t  s1_col_q, s1_col_d;
    logic  s1_sof_q, s1_sof_d;
    logic  s1_eol_q, s1_eol_d;
    logic  s1_pv_q, s1_pv_d;
    logic  s1_wr_q, s1_wr_d;

    // Forwarding for a read that collides with the write of the pixel just ahead
    logic  fwd_q, fwd_d;
    data_t fwd_data_q, fwd_data_d;

    // Stage 2: registered outputs
    logic  out_valid_q, out_valid_d;
    data_t out_cur_q, out_cur_d;
    data_t out_prev_q, out_prev_d;
    logic  out_prev_vld_q, out_prev_vld_d;
    logic  out_sof_q, out_sof_d;
    logic  out_eol_q, out_eol_d;

    cnt_t  ecol;
    cnt_t  ecol_inc;
    cnt_t  ecol_sat;
    logic  first_eff;
    logic  store;

    // NOTE: every signal assigned in this block gets a default at the top, so no
    // path through the if/else tree can leave one unassigned and infer a latch.
    always_comb begin
        ecol      = in_sof ? '0 : col_q;
        ecol_inc  = ecol + cnt_t'(1);
        ecol_sat  = (ecol_inc > MAX_COL) ? MAX_COL : ecol_inc;
        first_eff = in_sof | first_line_q;
        store     = ecol < MAX_COL;

        col_d        = col_q;
        first_line_d = first_line_q;
        prev_len_d   = prev_len_q;
        ovf_err_d    = ovf_err_q;
        line_len_d   = prev_len_q;

        if (in_valid) begin
            col_d = in_eol ? '0 : ecol_sat;
            if (in_eol) begin
                prev_len_d   = ecol_sat;
                first_line_d = 1'b0;
            end else if (in_sof) begin
                first_line_d = 1'b1;
            end
            if (!store) begin
                ovf_err_d = 1'b1;
            end
        end

        // Stage-1 fields are zeroed on idle cycles so bubbles carry no stale data.
        s1_valid_d = in_valid;
        s1_data_d  = in_valid ? in_data : '0;
        s1_col_d   = in_valid ? ecol : '0;
        s1_sof_d   = in_valid & in_sof;
        s1_eol_d   = in_valid & in_eol;
        s1_pv_d    = in_valid && !first_eff && (ecol < prev_len_q);
        s1_wr_d    = in_valid & store;

        // The RAM reads old data when a read meets a write to the same address.
        fwd_d      = in_valid && s1_valid_q && (ecol == s1_col_q);
        fwd_data_d = s1_data_q;

        out_valid_d    = s1_valid_q;
        out_cur_d      = s1_data_q;
        out_sof_d      = s1_sof_q;
        out_eol_d      = s1_eol_q;
        out_prev_vld_d = s1_pv_q;
        out_prev_d     = '0;
        if (s1_pv_q) begin
            out_prev_d = fwd_q ? fwd_data_q : ram_rd_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    // NOTE: reset clears only control and pipeline flops; the line contents live
    // in the external RAM and are never cleared, the prev-valid flag gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q          <= '0;
            first_line_q   <= 1'b1;
            prev_len_q     <= '0;
            line_len_q     <= '0;
            ovf_err_q      <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s1_col_q       <= '0;
            s1_sof_q       <= 1'b0;
            s1_eol_q       <= 1'b0;
            s1_pv_q        <= 1'b0;
            s1_wr_q        <= 1'b0;
            fwd_q          <= 1'b0;
            fwd_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_cur_q      <= '0;
            out_prev_q     <= '0;
            out_prev_vld_q <= 1'b0;
            out_sof_q      <= 1'b0;
            out_eol_q      <= 1'b0;
        end else begin
            col_q          <= col_d;
            first_line_q   <= first_line_d;
            prev_len_q     <= prev_len_d;
            line_len_q     <= line_len_d;
            ovf_err_q      <= ovf_err_d;
            s1_valid_q     <= s1_valid_d;
            s1_data_q      <= s1_data_d;
            s1_col_q       <= s1_col_d;
            s1_sof_q       <= s1_sof_d;
            s1_eol_q       <= s1_eol_d;
            s1_pv_q        <= s1_pv_d;
            s1_wr_q        <= s1_wr_d;
            fwd_q          <= fwd_d;
            fwd_data_q     <= fwd_data_d;
            out_valid_q    <= out_valid_d;
            out_cur_q      <= out_cur_d;
            out_prev_q     <= out_prev_d;
            out_prev_vld_q <= out_prev_vld_d;
            out_sof_q      <= out_sof_d;
            out_eol_q      <= out_eol_d;
        end
    end

    assign ram_rd_addr  = ecol[ADDR_WIDTH-1:0];
    assign ram_wr_en    = s1_wr_q;
    assign ram_wr_addr  = s1_col_q[ADDR_WIDTH-1:0];
    assign ram_wr_data  = s1_data_q;

    assign out_valid    = out_valid_q;
    assign out_cur      = out_cur_q;
    assign out_prev     = out_prev_q;
    assign out_prev_vld = out_prev_vld_q;
    assign out_sof      = out_sof_q;
    assign out_eol      = out_eol_q;
    assign line_len     = line_len_q;
    assign ovf_err      = ovf_err_q;

endmodule
